// File: rtl/adder8_bcd_pkg.sv
// Shared types and constants for the 8-bit adder with BCD 7-segment display.
// Holds the segment encoding table and the double-dabble helper.
package adder8_bcd_pkg;

  localparam int unsigned SegW = 7;

  typedef logic [SegW-1:0] seg_t;

  // Bit order is {a, b, c, d, e, f, g}, active-high.
  localparam seg_t SegDigits [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  localparam seg_t SegBlank = 7'b0000000;

  // Shift-add-3 over 8 input bits; returns {hundreds, tens, ones}.
  function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    return sh[19:8];
  endfunction

endpackage

// File: rtl/adder8_bcd_display_if.sv
// Operand and result bundle between an operand source and the adder/display block.
interface adder8_bcd_display_if;
  import adder8_bcd_pkg::*;

  logic [7:0] x;
  logic [7:0] y;
  logic       carry_in;
  logic [7:0] sum;
  logic       carry_out;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_ten;
  logic [3:0] bcd_one;
  seg_t       seg_hund;
  seg_t       seg_ten;
  seg_t       seg_one;

  modport master (
    output x, y, carry_in,
    input  sum, carry_out, bcd_hund, bcd_ten, bcd_one, seg_hund, seg_ten, seg_one
  );

  modport slave (
    input  x, y, carry_in,
    output sum, carry_out, bcd_hund, bcd_ten, bcd_one, seg_hund, seg_ten, seg_one
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to 7-segment decoder, active-high, codes 10..15 blank.
module bcd_to_seg7
  import adder8_bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SegBlank;
    case (bcd_i)
      4'd0:    seg_o = SegDigits[0];
      4'd1:    seg_o = SegDigits[1];
      4'd2:    seg_o = SegDigits[2];
      4'd3:    seg_o = SegDigits[3];
      4'd4:    seg_o = SegDigits[4];
      4'd5:    seg_o = SegDigits[5];
      4'd6:    seg_o = SegDigits[6];
      4'd7:    seg_o = SegDigits[7];
      4'd8:    seg_o = SegDigits[8];
      4'd9:    seg_o = SegDigits[9];
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/adder8_bcd_display.sv
// Registered 8-bit adder with carry, BCD conversion of the 8-bit sum and
// three-digit 7-segment decode of the registered digits.
module adder8_bcd_display
  import adder8_bcd_pkg::*;
#(
  parameter bit SegActiveLow = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  adder8_bcd_display_if.slave        bus_io
);

  logic [8:0]  sum9;
  logic [11:0] bcd_d;
  logic [7:0]  sum_q;
  logic        carry_q;
  logic [11:0] bcd_q;
  seg_t        seg_hund;
  seg_t        seg_ten;
  seg_t        seg_one;

  // Decimal value comes from the 8-bit sum only; the carry is never folded in.
  always_comb begin
    sum9  = {1'b0, bus_io.x} + {1'b0, bus_io.y} + {8'd0, bus_io.carry_in};
    bcd_d = bin_to_bcd(sum9[7:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q   <= 8'd0;
      carry_q <= 1'b0;
      bcd_q   <= 12'd0;
    end else begin
      sum_q   <= sum9[7:0];
      carry_q <= sum9[8];
      bcd_q   <= bcd_d;
    end
  end

  bcd_to_seg7 u_seg_hund (
    .bcd_i (bcd_q[11:8]),
    .seg_o (seg_hund)
  );

  bcd_to_seg7 u_seg_ten (
    .bcd_i (bcd_q[7:4]),
    .seg_o (seg_ten)
  );

  bcd_to_seg7 u_seg_one (
    .bcd_i (bcd_q[3:0]),
    .seg_o (seg_one)
  );

  assign bus_io.sum       = sum_q;
  assign bus_io.carry_out = carry_q;
  assign bus_io.bcd_hund  = bcd_q[11:8];
  assign bus_io.bcd_ten   = bcd_q[7:4];
  assign bus_io.bcd_one   = bcd_q[3:0];
  // Common-anode displays need every segment inverted.
  assign bus_io.seg_hund  = seg_hund ^ {SegW{SegActiveLow}};
  assign bus_io.seg_ten   = seg_ten ^ {SegW{SegActiveLow}};
  assign bus_io.seg_one   = seg_one ^ {SegW{SegActiveLow}};

endmodule

// File: tb/tb_adder8_bcd_display.sv
// Directed and random checks of adder8_bcd_display in active-high and active-low builds.
module tb_adder8_bcd_display;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  adder8_bcd_display_if bus ();
  adder8_bcd_display_if bus_n ();

  assign bus_n.x        = bus.x;
  assign bus_n.y        = bus.y;
  assign bus_n.carry_in = bus.carry_in;

  adder8_bcd_display #(.SegActiveLow(1'b0)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  adder8_bcd_display #(.SegActiveLow(1'b1)) u_dut_n (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] es, input logic eco,
                           input logic [3:0] eh, input logic [3:0] et, input logic [3:0] eo);
    cmp({tag, ".sum"}, {4'd0, bus.sum}, {4'd0, es});
    cmp({tag, ".co"}, {11'd0, bus.carry_out}, {11'd0, eco});
    cmp({tag, ".bcd"}, {bus.bcd_hund, bus.bcd_ten, bus.bcd_one}, {eh, et, eo});
    cmp({tag, ".seg_h"}, {5'd0, bus.seg_hund}, {5'd0, seg_of(eh)});
    cmp({tag, ".seg_t"}, {5'd0, bus.seg_ten}, {5'd0, seg_of(et)});
    cmp({tag, ".seg_o"}, {5'd0, bus.seg_one}, {5'd0, seg_of(eo)});
    cmp({tag, ".nseg_h"}, {5'd0, bus_n.seg_hund}, {5'd0, ~seg_of(eh)});
    cmp({tag, ".nseg_t"}, {5'd0, bus_n.seg_ten}, {5'd0, ~seg_of(et)});
    cmp({tag, ".nseg_o"}, {5'd0, bus_n.seg_one}, {5'd0, ~seg_of(eo)});
    cmp({tag, ".nsum"}, {4'd0, bus_n.sum}, {4'd0, es});
  endtask

  // Drive operands mid-cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic ci);
    @(negedge clk);
    bus.x        = x;
    bus.y        = y;
    bus.carry_in = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rci;
    logic [8:0] s9;
    logic [7:0] s8;
    total        = 0;
    bad          = 0;
    bus.x        = 8'd0;
    bus.y        = 8'd0;
    bus.carry_in = 1'b0;
    rst          = 1'b0;

    // Asynchronous reset applied before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_vec("reset_async", 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    step(8'd45, 8'd54, 1'b0);
    check_vec("45+54", 8'd99, 1'b0, 4'd0, 4'd9, 4'd9);
    step(8'd127, 8'd128, 1'b0);
    check_vec("127+128", 8'd255, 1'b0, 4'd2, 4'd5, 4'd5);
    step(8'd200, 8'd100, 1'b1);
    check_vec("200+100+1", 8'd45, 1'b1, 4'd0, 4'd4, 4'd5);
    step(8'd255, 8'd0, 1'b1);
    check_vec("255+0+1", 8'd0, 1'b1, 4'd0, 4'd0, 4'd0);
    step(8'd255, 8'd255, 1'b1);
    check_vec("255+255+1", 8'd255, 1'b1, 4'd2, 4'd5, 4'd5);
    step(8'd3, 8'd4, 1'b0);
    check_vec("3+4", 8'd7, 1'b0, 4'd0, 4'd0, 4'd7);
    step(8'd60, 8'd50, 1'b0);
    check_vec("60+50", 8'd110, 1'b0, 4'd1, 4'd1, 4'd0);

    // Reset asserted mid-stream clears outputs with no clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_vec("reset_mid", 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back random operands with a reset pulse in the middle.
    for (int i = 0; i < 24; i++) begin
      rx  = 8'($urandom_range(0, 255));
      ry  = 8'($urandom_range(0, 255));
      rci = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.x        = rx;
      bus.y        = ry;
      bus.carry_in = rci;
      rst          = (i == 10 || i == 11);
      @(posedge clk);
      #1;
      if (rst) begin
        check_vec("rand_rst", 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
      end else begin
        s9 = {1'b0, rx} + {1'b0, ry} + {8'd0, rci};
        s8 = s9[7:0];
        check_vec("rand", s8, s9[8], 4'(s8 / 100), 4'((s8 / 10) % 10), 4'(s8 % 10));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
